polilock_circuito_completo: RTL and testbench



---
 rtl/polilock_pkg.sv | 25 ++
 rtl/hexa7seg.sv | 27 ++
 rtl/polilock_circuito_completo.sv | 105 ++++++++++
 tb/tb_polilock_circuito_completo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/polilock_pkg.sv
// Shared types and constants for the Polilock password lock.
package polilock_pkg;

    localparam int N_CHARS_DEF = 10;

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        ESPERA    = 4'h1,
        V_ZERA    = 4'h2,
        V_CMP     = 4'h3,
        C_ZERA    = 4'h4,
        C_GRAVA   = 4'h5,
        ACERTOU   = 4'hA,
        BLOQUEADO = 4'hB,
        ERROU     = 4'hE
    } estado_t;

    localparam logic [1:0] FN_VERIFY = 2'b01;
    localparam logic [1:0] FN_CONFIG = 2'b10;

    // Index 0 is the first character; unused tail entries are zero.
    localparam logic [0:15][7:0] DEFAULT_PWD = {"Veriloguer", 48'h0};
    localparam logic [0:15][7:0] SERIAL_PWD  = {"VerilogueA", 48'h0};

endpackage

// File: rtl/hexa7seg.sv
// 4-bit to 7-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end
endmodule

// File: rtl/polilock_circuito_completo.sv
// Polilock top: FSM, address counter, password memories and debug displays.
// Optional LOCKOUT_EN macro enables the three-strikes BLOQUEADO state.
module polilock_circuito_completo
    import polilock_pkg::*;
#(
    parameter int N_CHARS = N_CHARS_DEF,
    parameter int ADDR_W  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] funcao,
    output logic       acertou,
    output logic       errou,
    output logic       db_bloqueado,
    output logic [6:0] db_estado,
    output logic [6:0] db_mem1,
    output logic [6:0] db_mem2,
    output logic [6:0] db_contagem
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CHARS - 1);

    estado_t           state, next_state;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        main_mem [16];
    logic [7:0]        main_chr, serial_chr;
    logic              lock_now;

    assign main_chr   = main_mem[cnt];
    assign serial_chr = SERIAL_PWD[cnt];

`ifdef LOCKOUT_EN
    logic [1:0] fail_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            fail_cnt <= 2'd0;
        else if (next_state == ACERTOU)
            fail_cnt <= 2'd0;
        else if (next_state == ERROU && state != ERROU)
            fail_cnt <= fail_cnt + 2'd1;
    end

    // Two errors already recorded: the next one locks instead.
    assign lock_now = (fail_cnt == 2'd2);
`else
    assign lock_now = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= INICIAL;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            INICIAL: if (iniciar) next_state = ESPERA;
            ESPERA: begin
                if (funcao == FN_VERIFY)      next_state = V_ZERA;
                else if (funcao == FN_CONFIG) next_state = C_ZERA;
            end
            V_ZERA:  next_state = V_CMP;
            V_CMP: begin
                if (main_chr != serial_chr) next_state = lock_now ? BLOQUEADO : ERROU;
                else if (cnt == LAST)       next_state = ACERTOU;
            end
            C_ZERA:  next_state = C_GRAVA;
            C_GRAVA: if (cnt == LAST) next_state = ESPERA;
            ACERTOU, ERROU: if (iniciar) next_state = ESPERA;
            BLOQUEADO: next_state = BLOQUEADO;
            default: next_state = INICIAL;
        endcase
    end

    // Reset reloads the stored password, so an aborted configure leaves no partial copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < 16; i++) main_mem[i] <= DEFAULT_PWD[i];
        end else begin
            unique case (state)
                V_ZERA, C_ZERA: cnt <= '0;
                V_CMP: if (main_chr == serial_chr && cnt < LAST) cnt <= cnt + 1'b1;
                C_GRAVA: begin
                    main_mem[cnt] <= serial_chr;
                    if (cnt < LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign acertou      = (state == ACERTOU);
    assign errou        = (state == ERROU) || (state == BLOQUEADO);
    assign db_bloqueado = (state != ACERTOU);

    hexa7seg u_seg_estado   (.hex(4'(state)),      .seg(db_estado));
    hexa7seg u_seg_mem1     (.hex(main_chr[3:0]),  .seg(db_mem1));
    hexa7seg u_seg_mem2     (.hex(serial_chr[3:0]),.seg(db_mem2));
    hexa7seg u_seg_contagem (.hex(4'(cnt)),        .seg(db_contagem));

endmodule

// File: tb/tb_polilock_circuito_completo.sv
// Directed bench for polilock_circuito_completo; honours LOCKOUT_EN when defined.
module tb_polilock_circuito_completo;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [1:0] funcao = 2'b00;
    logic       acertou, errou, db_bloqueado;
    logic [6:0] db_estado, db_mem1, db_mem2, db_contagem;

    int nvec = 0;
    int nerr = 0;

    // Active-low {g..a} patterns for the digits observed here.
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S4 = 7'h19,
                           S9 = 7'h10, SA = 7'h08, SB = 7'h03, SE = 7'h06, S6 = 7'h02;

    polilock_circuito_completo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .funcao(funcao),
        .acertou(acertou), .errou(errou), .db_bloqueado(db_bloqueado),
        .db_estado(db_estado), .db_mem1(db_mem1), .db_mem2(db_mem2),
        .db_contagem(db_contagem)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive funcao for 5 cycles, then wait (bounded) for db_estado to show target.
    task automatic do_op(input string tag, input logic [1:0] fn, input logic [6:0] target,
                         input int exp_cycles);
        int n;
        funcao = fn;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (i == 5) funcao = 2'b00;
            if (db_estado === target) begin
                n = i;
                break;
            end
        end
        funcao = 2'b00;
        chk(tag, n, exp_cycles);
    endtask

    initial begin
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_estado", db_estado, S0);
        chk("rst_acertou", acertou, 0);
        chk("rst_errou", errou, 0);
        chk("rst_bloq", db_bloqueado, 1);
        chk("rst_cnt", db_contagem, S0);
        chk("rst_mem1", db_mem1, S6);

        iniciar = 1'b1;
        step(5);
        iniciar = 1'b0;
        chk("espera", db_estado, S1);

        // 'r' vs 'A' at index 9: ERROU 12 edges after funcao is applied
        do_op("verify_fail_lat", 2'b01, SE, 12);
        chk("vf_errou", errou, 1);
        chk("vf_cnt", db_contagem, S9);
        chk("vf_mem1", db_mem1, S2);
        chk("vf_mem2", db_mem2, S1);
        chk("vf_bloq", db_bloqueado, 1);

        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        do_op("config_lat", 2'b10, S1, 12);
        chk("cfg_errou", errou, 0);
        chk("cfg_mem1_copied", db_mem1, S1);

        do_op("verify_ok_lat", 2'b01, SA, 12);
        chk("vo_acertou", acertou, 1);
        chk("vo_bloq", db_bloqueado, 0);
        chk("vo_cnt", db_contagem, S9);
        step(3);
        chk("vo_hold", db_estado, SA);

        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        chk("ack_estado", db_estado, S1);
        chk("ack_acertou", acertou, 0);

        funcao = 2'b11;
        step(3);
        chk("fn11_stay", db_estado, S1);
        iniciar = 1'b1;
        step(2);
        iniciar = 1'b0;
        chk("iniciar_ignored", db_estado, S1);
        funcao = 2'b00;

        // funcao switched to configure while verifying must not disturb it
        funcao = 2'b01;
        step(1);
        chk("mid_vzera", db_estado, 7'h24);
        funcao = 2'b10;
        step(10);
        chk("mid_vcmp", db_estado, 7'h30);
        step(1);
        chk("mid_acertou", db_estado, SA);
        funcao = 2'b00;
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;

        // held configure re-triggers on return to ESPERA
        funcao = 2'b10;
        step(12);
        chk("held_espera", db_estado, S1);
        step(1);
        chk("held_retrigger", db_estado, S4);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        funcao = 2'b00;
        chk("abort_estado", db_estado, S0);
        chk("abort_cnt", db_contagem, S0);

        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        do_op("restored_fail1", 2'b01, SE, 12);
        chk("restored_mem1", db_mem1, S2);
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        do_op("fail2", 2'b01, SE, 12);
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
`ifdef LOCKOUT_EN
        do_op("fail3_lock", 2'b01, SB, 12);
        chk("lock_errou", errou, 1);
        chk("lock_bloq", db_bloqueado, 1);
        iniciar = 1'b1;
        step(3);
        iniciar = 1'b0;
        chk("lock_stuck", db_estado, SB);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("lock_reset", db_estado, S0);
`else
        do_op("fail3_retry", 2'b01, SE, 12);
        chk("retry_errou", errou, 1);
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        chk("retry_back", db_estado, S1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
